// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial add sequencer.
package serial_add_pkg;

    // Sequencer states; DRAIN is only visited when the adder registers its result.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Carry out of the top bit, recovered from the operand MSBs and the sum MSB.
    function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand and result handshakes between a parallel requester and the sequencer.
interface serial_add_sequencer_if #(
    parameter int W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    // Requester side: offers operands and consumes the sum.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Parallel-to-serial controller for an external bit-serial adder: shifts the
// operands out LSB-first, collects the serial sum and presents it in parallel.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int W       = 8,
    parameter int RES_LAT = 1
) (
    input  logic                   clk,
    input  logic                   clear,
    serial_add_sequencer_if.slave  bus,
    output logic                   busy,
    output logic                   adder_clear,
    output logic                   adder_a,
    output logic                   adder_b,
    input  logic                   adder_result
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   res_sh_q, res_sh_d;
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cap_en;

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: IDLE -> CLR -> SHIFT x W -> (DRAIN) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CLR;
            CLR:     state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = (RES_LAT == 1) ? DRAIN : DONE;
            DRAIN:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sum bits appear RES_LAT cycles after their operand bits, so capture lags SHIFT by that much.
    generate
        if (RES_LAT == 0) begin : g_cap_comb
            assign cap_en = (state_q == SHIFT);
        end else begin : g_cap_reg
            logic cap_q, cap_d;
            // Delay the SHIFT indicator by one cycle to line up with the registered adder.
            always_comb cap_d = (state_q == SHIFT);
            // Capture-enable delay register.
            always_ff @(posedge clk or posedge clear) begin
                if (clear) cap_q <= 1'b0;
                else       cap_q <= cap_d;
            end
            assign cap_en = cap_q;
        end
    endgenerate

    // Datapath next values: operand load, shifting, bit count and result assembly.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.in_a;
                    b_sh_d   = bus.in_b;
                    a_msb_d  = bus.in_a[W-1];
                    b_msb_d  = bus.in_b[W-1];
                    res_sh_d = '0;
                end
            end
            CLR: cnt_d = '0;
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
            end
            default: ;
        endcase
        // Sum bits arrive LSB-first, so they enter at the top and walk down.
        if (cap_en) res_sh_d = {adder_result, res_sh_q[W-1:1]};
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from state and registers only; nothing passes straight from an input.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        busy          = (state_q != IDLE);
        adder_clear   = (state_q == CLR);
        adder_a       = 1'b0;
        adder_b       = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        case (state_q)
            SHIFT: begin
                adder_a = a_sh_q[0];
                adder_b = b_sh_q[0];
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = res_sh_q;
                bus.out_cout  = carry_out(a_msb_q, b_msb_q, res_sh_q[W-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench: two sequencers (registered and combinational serial adders) checked
// against plain-arithmetic expectations, directed tables and a random sweep.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    serial_add_sequencer_if #(.W(W)) if1 ();
    serial_add_sequencer_if #(.W(W)) if0 ();

    logic busy1, aclr1, aa1, ab1, ares1;
    logic busy0, aclr0, aa0, ab0, ares0;

    serial_add_sequencer #(.W(W), .RES_LAT(1)) dut1 (
        .clk(clk), .clear(clear), .bus(if1.slave), .busy(busy1),
        .adder_clear(aclr1), .adder_a(aa1), .adder_b(ab1), .adder_result(ares1)
    );

    serial_add_sequencer #(.W(W), .RES_LAT(0)) dut0 (
        .clk(clk), .clear(clear), .bus(if0.slave), .busy(busy0),
        .adder_clear(aclr0), .adder_a(aa0), .adder_b(ab0), .adder_result(ares0)
    );

    // Registered serial adder: sum bit appears one cycle after its operand bits.
    logic carry1, res1;
    always @(posedge clk or posedge clear) begin
        if (clear) begin
            carry1 <= 1'b0;
            res1   <= 1'b0;
        end else if (aclr1) begin
            carry1 <= 1'b0;
            res1   <= 1'b0;
        end else begin
            res1   <= aa1 ^ ab1 ^ carry1;
            carry1 <= (aa1 & ab1) | (aa1 & carry1) | (ab1 & carry1);
        end
    end
    assign ares1 = res1;

    // Combinational serial adder: sum bit in the same cycle, carry registered.
    logic carry0;
    always @(posedge clk or posedge clear) begin
        if (clear)      carry0 <= 1'b0;
        else if (aclr0) carry0 <= 1'b0;
        else            carry0 <= (aa0 & ab0) | (aa0 & carry0) | (ab0 & carry0);
    end
    assign ares0 = aa0 ^ ab0 ^ carry0;

    int n_vec = 0;
    int n_err = 0;
    int sel   = 1;

    logic         m_in_ready, m_out_valid, m_out_cout, m_busy, m_aclr, m_aa, m_ab;
    logic [W-1:0] m_out_sum;
    assign m_in_ready  = (sel == 1) ? if1.in_ready  : if0.in_ready;
    assign m_out_valid = (sel == 1) ? if1.out_valid : if0.out_valid;
    assign m_out_sum   = (sel == 1) ? if1.out_sum   : if0.out_sum;
    assign m_out_cout  = (sel == 1) ? if1.out_cout  : if0.out_cout;
    assign m_busy      = (sel == 1) ? busy1 : busy0;
    assign m_aclr      = (sel == 1) ? aclr1 : aclr0;
    assign m_aa        = (sel == 1) ? aa1   : aa0;
    assign m_ab        = (sel == 1) ? ab1   : ab0;

    typedef struct {
        int           sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        int           lat;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (dut RES_LAT=%0d)", name, act, exp, (sel == 1) ? 1 : 0);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel == 1) begin
            if1.in_valid = v; if1.in_a = a; if1.in_b = b;
        end else begin
            if0.in_valid = v; if0.in_a = a; if0.in_b = b;
        end
    endtask

    task automatic set_ready(input logic r);
        if (sel == 1) if1.out_ready = r;
        else          if0.out_ready = r;
    endtask

    function automatic logic [31:0] reset_pack();
        return {17'd0, m_in_ready, m_out_valid, m_out_sum, m_out_cout, m_busy, m_aclr, m_aa, m_ab};
    endfunction

    // Expected reset pattern: only in_ready high.
    localparam logic [31:0] RESET_PACK = 32'h4000;

    // Wait (bounded) for in_ready, present operands for one edge, then scramble them.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (m_in_ready) seen = 1;
        end
        check("in_ready_before_accept", {31'd0, m_in_ready}, 32'd1);
        drive(1'b1, a, b);
        @(posedge clk);
        #1;
        drive(1'b0, W'($urandom), W'($urandom));
    endtask

    // Count edges until out_valid; the accepting edge is counted as the first.
    task automatic wait_done(output int lat, output int clr_cnt, output int rdy_hi);
        lat     = 1;
        clr_cnt = int'(m_aclr);
        rdy_hi  = int'(m_in_ready);
        while (!m_out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            clr_cnt += int'(m_aclr);
            rdy_hi  += int'(m_in_ready);
        end
        check("out_valid_seen", {31'd0, m_out_valid}, 32'd1);
    endtask

    task automatic handshake();
        set_ready(1'b1);
        @(posedge clk);
        #1;
        check("in_ready_after_handshake", {31'd0, m_in_ready}, 32'd1);
        check("out_valid_after_handshake", {31'd0, m_out_valid}, 32'd0);
    endtask

    // One full operation; hold cycles of back-pressure before the consumer takes the sum.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                          input logic c, input int exp_lat, input int hold);
        int lat, clr_cnt, rdy_hi;
        set_ready(hold == 0);
        start_op(a, b);
        wait_done(lat, clr_cnt, rdy_hi);
        if (exp_lat > 0) begin
            check("latency", lat, exp_lat);
            check("adder_clear_cycles", clr_cnt, 32'd1);
            check("in_ready_while_busy", rdy_hi, 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        check("out_sum", {24'd0, m_out_sum}, {24'd0, s});
        check("out_cout", {31'd0, m_out_cout}, {31'd0, c});
        $display("op sel=%0d a=%0d b=%0d -> sum=%0d cout=%0d lat=%0d", sel, a, b, m_out_sum, m_out_cout, lat);
        handshake();
    endtask

    initial begin
        logic [W:0]   full;
        logic [W-1:0] ra, rb;
        int lat, clr_cnt, rdy_hi;

        tbl[0] = '{1,   8'd7,   8'd3,  8'd10, 1'b0, 11};
        tbl[1] = '{1, 8'd200, 8'd100,  8'd44, 1'b1, 11};
        tbl[2] = '{1, 8'd255,   8'd1,   8'd0, 1'b1, 11};
        tbl[3] = '{0,   8'd7,   8'd3,  8'd10, 1'b0, 10};
        tbl[4] = '{0, 8'd128, 8'd128,   8'd0, 1'b1, 10};
        tbl[5] = '{1, 8'd255, 8'd255, 8'd254, 1'b1, 11};
        tbl[6] = '{0,   8'd0,   8'd0,   8'd0, 1'b0, 10};
        tbl[7] = '{1,  8'd85, 8'd170, 8'd255, 1'b0, 11};

        clear = 1'b1;
        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
        if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b0;
        #12;
        sel = 1;
        #0 check("reset_outputs", reset_pack(), RESET_PACK);
        sel = 0;
        #0 check("reset_outputs", reset_pack(), RESET_PACK);
        @(negedge clk);
        clear = 1'b0;

        // Directed table on both flavours.
        for (int i = 0; i < 8; i++) begin
            sel = tbl[i].sel;
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].lat, 0);
        end

        // Back-pressure: sum must hold and a request while busy must be dropped.
        sel = 1;
        set_ready(1'b0);
        start_op(8'd5, 8'd9);
        wait_done(lat, clr_cnt, rdy_hi);
        check("hold_in_ready_while_busy", rdy_hi, 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("hold_out_sum", {24'd0, m_out_sum}, 32'd14);
            check("hold_out_valid", {31'd0, m_out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, m_in_ready}, 32'd0);
            if (i == 5)      drive(1'b1, 8'd1, 8'd1);
            else if (i == 6) drive(1'b0, 8'd0, 8'd0);
            @(posedge clk);
            #1;
        end
        $display("hold sel=1 a=5 b=9 -> sum=%0d cout=%0d", m_out_sum, m_out_cout);
        handshake();
        @(posedge clk);
        #1;
        check("dropped_request_not_queued", {31'd0, m_busy}, 32'd0);
        run_op(8'd1, 8'd1, 8'd2, 1'b0, 11, 0);

        // Asynchronous reset in the middle of shifting (bit counter at 4).
        set_ready(1'b1);
        start_op(8'd127, 8'd1);
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_midop_reset", {31'd0, m_busy}, 32'd1);
        #2;
        clear = 1'b1;
        #1;
        check("midop_reset_outputs", reset_pack(), RESET_PACK);
        $display("reset mid-shift sel=1 -> outputs=%04h", reset_pack());
        @(negedge clk);
        clear = 1'b0;
        run_op(8'd127, 8'd1, 8'd128, 1'b0, 11, 0);

        // Random sweep against plain addition.
        for (int i = 0; i < 650; i++) begin
            sel  = (i < 500) ? 0 : 1;
            ra   = W'($urandom);
            rb   = W'($urandom);
            full = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, full[W-1:0], full[W], 0, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
